// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the full-subtractor bit equations.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic fs_diff(input logic a, input logic b, input logic bin);
        return a ^ b ^ bin;
    endfunction

    // Borrow out when a < b + bin for a single bit.
    function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
        return (~a & b) | (~(a ^ b) & bin);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit combinational full subtractor: d = a - b - bin, with borrow out.
import serial_subtractor_pkg::*;

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = fs_diff(a, b, bin);
    assign bout = fs_borrow(a, b, bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b), LSB first, one full-subtractor cell
// plus a registered borrow, behind a start/done handshake.
import serial_subtractor_pkg::*;

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("serial_subtractor: WIDTH must be at least 2");
        end
    endgenerate

    state_t state_q, state_d;
    logic   load, shift, last;

    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic             fs_d, fs_b;

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_b)
    );

    assign last = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // busy/done are decoded from the next state so both leave the block as flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == RUN);
            done    <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            br_q  <= 1'b0;
            cnt_q <= '0;
            diff  <= '0;
            bout  <= 1'b0;
        end else if (load) begin
            a_sh  <= a;
            b_sh  <= b;
            br_q  <= 1'b0;
            cnt_q <= '0;
        end else if (shift) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            r_sh  <= {fs_d, r_sh[WIDTH-1:1]};
            br_q  <= fs_b;
            cnt_q <= cnt_q + 1'b1;
            // The last bit lands straight in the result so diff is complete on DONE entry.
            if (last) begin
                diff <= {fs_d, r_sh[WIDTH-1:1]};
                bout <= fs_b;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with a cycle-level reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, bout;
    logic [W-1:0] diff;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted start yields busy for W cycles, then one done cycle
    // carrying {bout,diff} = a - b computed in W+1 bits.
    logic         m_busy, m_done, m_bout;
    logic [W-1:0] m_diff;
    logic [W:0]   pend;
    int           left;
    bit           acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_diff = '0; m_bout = 1'b0; left = 0;
        end else begin
            acc    = start && !m_busy;
            m_done = 1'b0;
            if (m_busy) begin
                left = left - 1;
                if (left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    {m_bout, m_diff} = pend;
                end
            end
            if (acc) begin
                pend   = {1'b0, a} - {1'b0, b};
                left   = W;
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("diff", 32'(diff), 32'(m_diff));
            chk("bout", 32'(bout), 32'(m_bout));
        end
    end

    // Issue one start and wait (bounded) for done; lat counts negedges after the start edge.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int bcyc, output bit ok);
        @(negedge clk);
        start = 1'b1; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        lat = 0; bcyc = 0; ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                ok = 1'b1;
                lat = i;
                break;
            end
            if (busy) bcyc++;
            @(negedge clk);
        end
        if (!ok) begin
            errors++;
            checks++;
            $display("FAIL done_timeout actual=none expected=done a=%0d b=%0d", x, y);
        end
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    int lat, bcyc, nd;
    bit ok;

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_diff", 32'(diff), 0);
        chk("rst_bout", 32'(bout), 0);
        rst_n = 1'b1;
        count_dones(4, nd);
        chk("idle_no_done", nd, 0);

        // Basic subtraction
        run_op(8'd100, 8'd37, lat, bcyc, ok);
        chk("basic_latency", lat, 8);
        chk("basic_busy_cycles", bcyc, 8);
        chk("basic_diff", 32'(diff), 63);
        chk("basic_bout", 32'(bout), 0);

        // Borrow cases
        run_op(8'd5, 8'd9, lat, bcyc, ok);
        chk("b59_diff", 32'(diff), 32'h0FC);
        chk("b59_bout", 32'(bout), 1);
        run_op(8'd0, 8'd1, lat, bcyc, ok);
        chk("b01_diff", 32'(diff), 32'h0FF);
        chk("b01_bout", 32'(bout), 1);
        run_op(8'hFF, 8'hFF, lat, bcyc, ok);
        chk("bff_diff", 32'(diff), 0);
        chk("bff_bout", 32'(bout), 0);
        @(negedge clk);
        chk("result_held_idle", 32'(diff), 0);

        // Start ignored during RUN
        @(negedge clk);
        start = 1'b1; a = 8'd20; b = 8'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; a = 8'd1; b = 8'd2;
        @(negedge clk);
        start = 1'b0;
        count_dones(16, nd);
        chk("ignore_done_count", nd, 1);
        chk("ignore_diff", 32'(diff), 17);
        chk("ignore_bout", 32'(bout), 0);
        chk("ignore_busy_after", 32'(busy), 0);

        // Reset mid-operation
        @(negedge clk);
        start = 1'b1; a = 8'd100; b = 8'd37;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_diff", 32'(diff), 0);
        chk("midrst_bout", 32'(bout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(16, nd);
        chk("midrst_no_done", nd, 0);

        // Back-to-back: new start in the DONE cycle
        run_op(8'd50, 8'd10, lat, bcyc, ok);
        chk("b2b_first_diff", 32'(diff), 40);
        start = 1'b1; a = 8'd200; b = 8'd201;
        @(negedge clk);
        start = 1'b0;
        lat = 1; ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (lat == 5) chk("b2b_first_held", 32'(diff), 40);
            if (done) begin
                ok = 1'b1;
                break;
            end
            lat++;
            @(negedge clk);
        end
        chk("b2b_second_seen", 32'(ok), 1);
        chk("b2b_spacing", lat, 9);
        chk("b2b_diff", 32'(diff), 32'h0FF);
        chk("b2b_bout", 32'(bout), 1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
